// File: rtl/zx8x_kbd_pkg.sv
// Shared types and PS/2 set-2 scancode constants for the ZX80/ZX81 keyboard matrix.
package zx8x_kbd_pkg;

  localparam int NUM_ROWS = 8;
  localparam int NUM_COLS = 5;

  typedef logic [2:0] row_t;
  typedef logic [2:0] col_t;

  // One matrix position; virt_shift marks a compound key that also implies SHIFT.
  typedef struct packed {
    logic valid;
    row_t row;
    col_t col;
    logic virt_shift;
  } map_entry_t;

  // Modifier keys are tracked per side so releasing one side keeps the other held.
  typedef enum logic [2:0] {
    MOD_NONE    = 3'd0,
    MOD_SHIFT_L = 3'd1,
    MOD_SHIFT_R = 3'd2,
    MOD_CTRL_L  = 3'd3,
    MOD_CTRL_R  = 3'd4,
    MOD_ALT_L   = 3'd5,
    MOD_ALT_R   = 3'd6
  } mod_sel_t;

  localparam map_entry_t NO_KEY = '0;

  // Matrix rows A8..A15
  localparam logic [7:0] SC_LSHIFT = 8'h12, SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_Z = 8'h1A, SC_X = 8'h22, SC_C = 8'h21, SC_V = 8'h2A;
  localparam logic [7:0] SC_A = 8'h1C, SC_S = 8'h1B, SC_D = 8'h23, SC_F = 8'h2B, SC_G = 8'h34;
  localparam logic [7:0] SC_Q = 8'h15, SC_W = 8'h1D, SC_E = 8'h24, SC_R = 8'h2D, SC_T = 8'h2C;
  localparam logic [7:0] SC_1 = 8'h16, SC_2 = 8'h1E, SC_3 = 8'h26, SC_4 = 8'h25, SC_5 = 8'h2E;
  localparam logic [7:0] SC_0 = 8'h45, SC_9 = 8'h46, SC_8 = 8'h3E, SC_7 = 8'h3D, SC_6 = 8'h36;
  localparam logic [7:0] SC_P = 8'h4D, SC_O = 8'h44, SC_I = 8'h43, SC_U = 8'h3C, SC_Y = 8'h35;
  localparam logic [7:0] SC_ENTER = 8'h5A, SC_L = 8'h4B, SC_K = 8'h42, SC_J = 8'h3B, SC_H = 8'h33;
  localparam logic [7:0] SC_SPACE = 8'h29, SC_DOT = 8'h49, SC_M = 8'h3A, SC_N = 8'h31, SC_B = 8'h32;

  // Compound keys (cursor keys are E0-extended, backspace is not)
  localparam logic [7:0] SC_LEFT = 8'h6B, SC_DOWN = 8'h72, SC_UP = 8'h75, SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_BKSP = 8'h66;

  // Modifiers
  localparam logic [7:0] SC_CTRL = 8'h14, SC_ALT = 8'h11;

  // Function keys F1..F11
  localparam logic [7:0] SC_F1 = 8'h05, SC_F2 = 8'h06, SC_F3 = 8'h04, SC_F4 = 8'h0C;
  localparam logic [7:0] SC_F5 = 8'h03, SC_F6 = 8'h0B, SC_F7 = 8'h83, SC_F8 = 8'h0A;
  localparam logic [7:0] SC_F9 = 8'h01, SC_F10 = 8'h09, SC_F11 = 8'h78;

  function automatic map_entry_t key_at(input row_t r, input col_t c, input logic v);
    map_entry_t e;
    e.valid      = 1'b1;
    e.row        = r;
    e.col        = c;
    e.virt_shift = v;
    return e;
  endfunction

endpackage

// File: rtl/zx8x_scancode_map.sv
// Combinational lookup from {E0 flag, scancode} to matrix position, Fn index and modifier.
module zx8x_scancode_map
  import zx8x_kbd_pkg::*;
#(
  parameter int CURSOR_MAP = 1
) (
  input  logic       ext,
  input  logic [7:0] code,
  output map_entry_t entry,
  output logic [3:0] fn_idx,
  output mod_sel_t   mod_sel
);

  // Decode the scancode; anything not listed leaves all outputs at "no key".
  always_comb begin
    entry   = NO_KEY;
    fn_idx  = 4'd0;
    mod_sel = MOD_NONE;
    if (!ext) begin
      case (code)
        SC_LSHIFT: mod_sel = MOD_SHIFT_L;
        SC_RSHIFT: mod_sel = MOD_SHIFT_R;
        SC_Z:      entry = key_at(3'd0, 3'd1, 1'b0);
        SC_X:      entry = key_at(3'd0, 3'd2, 1'b0);
        SC_C:      entry = key_at(3'd0, 3'd3, 1'b0);
        SC_V:      entry = key_at(3'd0, 3'd4, 1'b0);
        SC_A:      entry = key_at(3'd1, 3'd0, 1'b0);
        SC_S:      entry = key_at(3'd1, 3'd1, 1'b0);
        SC_D:      entry = key_at(3'd1, 3'd2, 1'b0);
        SC_F:      entry = key_at(3'd1, 3'd3, 1'b0);
        SC_G:      entry = key_at(3'd1, 3'd4, 1'b0);
        SC_Q:      entry = key_at(3'd2, 3'd0, 1'b0);
        SC_W:      entry = key_at(3'd2, 3'd1, 1'b0);
        SC_E:      entry = key_at(3'd2, 3'd2, 1'b0);
        SC_R:      entry = key_at(3'd2, 3'd3, 1'b0);
        SC_T:      entry = key_at(3'd2, 3'd4, 1'b0);
        SC_1:      entry = key_at(3'd3, 3'd0, 1'b0);
        SC_2:      entry = key_at(3'd3, 3'd1, 1'b0);
        SC_3:      entry = key_at(3'd3, 3'd2, 1'b0);
        SC_4:      entry = key_at(3'd3, 3'd3, 1'b0);
        SC_5:      entry = key_at(3'd3, 3'd4, 1'b0);
        SC_0:      entry = key_at(3'd4, 3'd0, 1'b0);
        SC_9:      entry = key_at(3'd4, 3'd1, 1'b0);
        SC_8:      entry = key_at(3'd4, 3'd2, 1'b0);
        SC_7:      entry = key_at(3'd4, 3'd3, 1'b0);
        SC_6:      entry = key_at(3'd4, 3'd4, 1'b0);
        SC_P:      entry = key_at(3'd5, 3'd0, 1'b0);
        SC_O:      entry = key_at(3'd5, 3'd1, 1'b0);
        SC_I:      entry = key_at(3'd5, 3'd2, 1'b0);
        SC_U:      entry = key_at(3'd5, 3'd3, 1'b0);
        SC_Y:      entry = key_at(3'd5, 3'd4, 1'b0);
        SC_ENTER:  entry = key_at(3'd6, 3'd0, 1'b0);
        SC_L:      entry = key_at(3'd6, 3'd1, 1'b0);
        SC_K:      entry = key_at(3'd6, 3'd2, 1'b0);
        SC_J:      entry = key_at(3'd6, 3'd3, 1'b0);
        SC_H:      entry = key_at(3'd6, 3'd4, 1'b0);
        SC_SPACE:  entry = key_at(3'd7, 3'd0, 1'b0);
        SC_DOT:    entry = key_at(3'd7, 3'd1, 1'b0);
        SC_M:      entry = key_at(3'd7, 3'd2, 1'b0);
        SC_N:      entry = key_at(3'd7, 3'd3, 1'b0);
        SC_B:      entry = key_at(3'd7, 3'd4, 1'b0);
        SC_BKSP:   if (CURSOR_MAP != 0) entry = key_at(3'd4, 3'd0, 1'b1);
        SC_CTRL:   mod_sel = MOD_CTRL_L;
        SC_ALT:    mod_sel = MOD_ALT_L;
        SC_F1:     fn_idx = 4'd1;
        SC_F2:     fn_idx = 4'd2;
        SC_F3:     fn_idx = 4'd3;
        SC_F4:     fn_idx = 4'd4;
        SC_F5:     fn_idx = 4'd5;
        SC_F6:     fn_idx = 4'd6;
        SC_F7:     fn_idx = 4'd7;
        SC_F8:     fn_idx = 4'd8;
        SC_F9:     fn_idx = 4'd9;
        SC_F10:    fn_idx = 4'd10;
        SC_F11:    fn_idx = 4'd11;
        default:   ;
      endcase
    end else begin
      // E0-extended: keypad Enter, right ctrl/alt and cursor keys only;
      // E0 12 / E0 59 are fake shifts and fall through to the default.
      case (code)
        SC_ENTER: entry = key_at(3'd6, 3'd0, 1'b0);
        SC_CTRL:  mod_sel = MOD_CTRL_R;
        SC_ALT:   mod_sel = MOD_ALT_R;
        SC_LEFT:  if (CURSOR_MAP != 0) entry = key_at(3'd3, 3'd4, 1'b1);
        SC_DOWN:  if (CURSOR_MAP != 0) entry = key_at(3'd4, 3'd4, 1'b1);
        SC_UP:    if (CURSOR_MAP != 0) entry = key_at(3'd4, 3'd3, 1'b1);
        SC_RIGHT: if (CURSOR_MAP != 0) entry = key_at(3'd4, 3'd2, 1'b1);
        default:  ;
      endcase
    end
  end

endmodule

// File: rtl/zx8x_key_matrix.sv
// PS/2 event decoder holding the ZX80/ZX81 8x5 key matrix, Fn and modifier state.
module zx8x_key_matrix
  import zx8x_kbd_pkg::*;
#(
  parameter int CURSOR_MAP = 1,
  parameter int NUM_FN     = 11
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [10:0]   ps2_key,
  input  logic [15:0]   addr,
  output logic [4:0]    key_data,
  output logic [NUM_FN:1] Fn,
  output logic [2:0]    mod
);

  logic                  old_toggle;
  logic [7:0][4:0]       phys_reg, phys_next;
  logic [7:0][4:0]       virt_reg, virt_next;
  logic [NUM_FN:1]       fn_reg, fn_next;
  // {alt_r, alt_l, ctrl_r, ctrl_l, shift_r, shift_l}
  logic [5:0]            mod_reg, mod_next;
  logic [7:0][4:0]       held;

  map_entry_t entry;
  logic [3:0] fn_idx;
  mod_sel_t   mod_sel;
  logic       key_event;
  logic       press;
  logic       unused_addr;

  assign key_event   = ps2_key[10] != old_toggle;
  assign press       = ps2_key[9];
  assign unused_addr = ^addr[7:0];

  zx8x_scancode_map #(
    .CURSOR_MAP(CURSOR_MAP)
  ) u_map (
    .ext    (ps2_key[8]),
    .code   (ps2_key[7:0]),
    .entry  (entry),
    .fn_idx (fn_idx),
    .mod_sel(mod_sel)
  );

  // Next state: a press sets and a release clears the decoded bit; unmapped codes change nothing.
  always_comb begin
    phys_next = phys_reg;
    virt_next = virt_reg;
    fn_next   = fn_reg;
    mod_next  = mod_reg;
    if (key_event) begin
      if (entry.valid) begin
        if (entry.virt_shift) virt_next[entry.row][entry.col] = press;
        else                  phys_next[entry.row][entry.col] = press;
      end
      for (int i = 1; i <= NUM_FN; i++) begin
        if (fn_idx == 4'(i)) fn_next[i] = press;
      end
      case (mod_sel)
        MOD_SHIFT_L: mod_next[0] = press;
        MOD_SHIFT_R: mod_next[1] = press;
        MOD_CTRL_L:  mod_next[2] = press;
        MOD_CTRL_R:  mod_next[3] = press;
        MOD_ALT_L:   mod_next[4] = press;
        MOD_ALT_R:   mod_next[5] = press;
        default:     ;
      endcase
    end
  end

  // State registers; the toggle is resampled during reset so leaving reset never fires an event.
  always_ff @(posedge clk_sys) begin
    old_toggle <= ps2_key[10];
    if (reset) begin
      phys_reg <= '0;
      virt_reg <= '0;
      fn_reg   <= '0;
      mod_reg  <= '0;
    end else begin
      phys_reg <= phys_next;
      virt_reg <= virt_next;
      fn_reg   <= fn_next;
      mod_reg  <= mod_next;
    end
  end

  // Effective matrix: physical OR compound bits; SHIFT also lit by either shift key or any compound key.
  always_comb begin
    held       = phys_reg | virt_reg;
    held[0][0] = held[0][0] | mod_reg[0] | mod_reg[1] | (|virt_reg);
  end

  // Column read: a column is pulled low if any address-selected row holds it.
  for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
    logic [7:0] col_bits;
    for (genvar gr = 0; gr < NUM_ROWS; gr++) begin : g_row
      assign col_bits[gr] = held[gr][gi];
    end
    assign key_data[gi] = ~|(col_bits & ~addr[15:8]);
  end

  assign Fn  = fn_reg;
  assign mod = {mod_reg[5] | mod_reg[4], mod_reg[3] | mod_reg[2], mod_reg[1] | mod_reg[0]};

endmodule

// File: tb/tb_zx8x_key_matrix.sv
// Self-checking bench for zx8x_key_matrix: directed vector table, corner sequences, random events vs a key-set model.
module tb_zx8x_key_matrix;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [15:0] addr;
  logic [4:0]  key_data;
  logic [11:1] fn;
  logic [2:0]  mod;

  int errors = 0;
  int checks = 0;

  always #5 clk_sys = ~clk_sys;

  zx8x_key_matrix #(.CURSOR_MAP(1), .NUM_FN(11)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ps2_key (ps2_key),
    .addr    (addr),
    .key_data(key_data),
    .Fn      (fn),
    .mod     (mod)
  );

  // Reference model: set of held keys, keyed by {E0, scancode}.
  bit held_m[512];

  int row_codes[8][5] = '{
    '{0,     'h1A, 'h22, 'h21, 'h2A},
    '{'h1C,  'h1B, 'h23, 'h2B, 'h34},
    '{'h15,  'h1D, 'h24, 'h2D, 'h2C},
    '{'h16,  'h1E, 'h26, 'h25, 'h2E},
    '{'h45,  'h46, 'h3E, 'h3D, 'h36},
    '{'h4D,  'h44, 'h43, 'h3C, 'h35},
    '{'h5A,  'h4B, 'h42, 'h3B, 'h33},
    '{'h29,  'h49, 'h3A, 'h31, 'h32}
  };
  // Compound keys: id and the digit they press together with SHIFT.
  int cur_code[5] = '{'h16B, 'h172, 'h175, 'h174, 'h066};
  int cur_row[5]  = '{3, 4, 4, 4, 4};
  int cur_col[5]  = '{4, 4, 3, 2, 0};
  int fn_codes[11] = '{'h05, 'h06, 'h04, 'h0C, 'h03, 'h0B, 'h83, 'h0A, 'h01, 'h09, 'h78};

  function automatic void model_clear();
    for (int i = 0; i < 512; i++) held_m[i] = 1'b0;
  endfunction

  function automatic void model_event(bit ext, bit prs, logic [7:0] code);
    int id;
    id = ext ? (256 + int'(code)) : int'(code);
    if (id == 'h15A) id = 'h05A;  // keypad Enter shares the ENTER key
    held_m[id] = prs;
  endfunction

  function automatic bit pos_on(int r, int c);
    bit v;
    v = 1'b0;
    if (r == 0 && c == 0) begin
      v = held_m['h12] | held_m['h59];
      for (int k = 0; k < 5; k++) v |= held_m[cur_code[k]];
    end else begin
      v = held_m[row_codes[r][c]];
      for (int k = 0; k < 5; k++)
        if (cur_row[k] == r && cur_col[k] == c) v |= held_m[cur_code[k]];
    end
    return v;
  endfunction

  function automatic logic [4:0] exp_kd(logic [15:0] a);
    logic [4:0] kd;
    for (int c = 0; c < 5; c++) begin
      bit any;
      any = 1'b0;
      for (int r = 0; r < 8; r++)
        if (!a[8+r]) any |= pos_on(r, c);
      kd[c] = ~any;
    end
    return kd;
  endfunction

  function automatic logic [11:1] exp_fn();
    logic [11:1] f;
    for (int n = 0; n < 11; n++) f[n+1] = held_m[fn_codes[n]];
    return f;
  endfunction

  function automatic logic [2:0] exp_mod();
    return {held_m['h11] | held_m['h111], held_m['h14] | held_m['h114], held_m['h12] | held_m['h59]};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one PS/2 event; outputs are sampled 1 ns after the edge that absorbs it.
  task automatic send(input bit ext, input bit prs, input logic [7:0] code);
    ps2_key = {~ps2_key[10], prs, ext, code};
    model_event(ext, prs, code);
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  typedef struct {
    bit          ev;
    bit          ext;
    bit          prs;
    logic [7:0]  code;
    logic [15:0] a;
    logic [4:0]  kd;
    logic [11:1] f;
    logic [2:0]  md;
  } vec_t;

  function automatic vec_t mkv(bit ev, bit ext, bit prs, logic [7:0] code, logic [15:0] a,
                               logic [4:0] kd, logic [11:1] f, logic [2:0] md);
    vec_t v;
    v.ev = ev; v.ext = ext; v.prs = prs; v.code = code; v.a = a;
    v.kd = kd; v.f = f; v.md = md;
    return v;
  endfunction

  vec_t vecs[$];
  int   pool[$];

  initial begin
    // Directed vectors: {event?, E0, press, code, addr, key_data, Fn, mod}
    vecs.push_back(mkv(1, 0, 1, 8'h1A, 16'hFEFE, 5'h1D, 11'h000, 3'b000)); // Z down
    vecs.push_back(mkv(0, 0, 0, 8'h00, 16'hFDFE, 5'h1F, 11'h000, 3'b000)); // other row
    vecs.push_back(mkv(1, 0, 0, 8'h1A, 16'hFEFE, 5'h1F, 11'h000, 3'b000)); // Z up
    vecs.push_back(mkv(1, 0, 1, 8'h1A, 16'hFEFE, 5'h1D, 11'h000, 3'b000)); // typematic
    vecs.push_back(mkv(1, 0, 1, 8'h1A, 16'hFEFE, 5'h1D, 11'h000, 3'b000));
    vecs.push_back(mkv(1, 0, 0, 8'h1A, 16'hFEFE, 5'h1F, 11'h000, 3'b000));
    vecs.push_back(mkv(1, 0, 0, 8'h1A, 16'hFEFE, 5'h1F, 11'h000, 3'b000)); // release unheld
    vecs.push_back(mkv(1, 1, 1, 8'h6B, 16'hFEFE, 5'h1E, 11'h000, 3'b000)); // cursor left
    vecs.push_back(mkv(0, 0, 0, 8'h00, 16'hF7FE, 5'h0F, 11'h000, 3'b000));
    vecs.push_back(mkv(1, 0, 1, 8'h12, 16'hFEFE, 5'h1E, 11'h000, 3'b001)); // real shift
    vecs.push_back(mkv(1, 1, 0, 8'h6B, 16'hFEFE, 5'h1E, 11'h000, 3'b001));
    vecs.push_back(mkv(0, 0, 0, 8'h00, 16'hF7FE, 5'h1F, 11'h000, 3'b001));
    vecs.push_back(mkv(1, 0, 1, 8'h59, 16'hFEFE, 5'h1E, 11'h000, 3'b001)); // both shifts
    vecs.push_back(mkv(1, 0, 0, 8'h12, 16'hFEFE, 5'h1E, 11'h000, 3'b001));
    vecs.push_back(mkv(1, 0, 0, 8'h59, 16'hFEFE, 5'h1F, 11'h000, 3'b000));
    vecs.push_back(mkv(1, 1, 1, 8'h12, 16'hFEFE, 5'h1F, 11'h000, 3'b000)); // fake shift
    vecs.push_back(mkv(1, 1, 1, 8'h5A, 16'hBFFE, 5'h1E, 11'h000, 3'b000)); // keypad Enter
    vecs.push_back(mkv(1, 1, 1, 8'h75, 16'hEFFE, 5'h17, 11'h000, 3'b000)); // cursor up = 7
    vecs.push_back(mkv(0, 0, 0, 8'h00, 16'hEEFE, 5'h16, 11'h000, 3'b000)); // wired-AND
    vecs.push_back(mkv(1, 1, 0, 8'h75, 16'hEFFE, 5'h1F, 11'h000, 3'b000));
    vecs.push_back(mkv(1, 1, 0, 8'h5A, 16'hBFFE, 5'h1F, 11'h000, 3'b000));
    vecs.push_back(mkv(1, 1, 1, 8'h1A, 16'hFEFE, 5'h1F, 11'h000, 3'b000)); // E0 Z unmapped
    vecs.push_back(mkv(1, 0, 1, 8'h66, 16'hEFFE, 5'h1E, 11'h000, 3'b000)); // bksp = 0
    vecs.push_back(mkv(1, 0, 0, 8'h66, 16'h00FE, 5'h1F, 11'h000, 3'b000));
    vecs.push_back(mkv(1, 0, 1, 8'h05, 16'hFEFE, 5'h1F, 11'h001, 3'b000)); // F1
    vecs.push_back(mkv(1, 1, 1, 8'h11, 16'hFEFE, 5'h1F, 11'h001, 3'b100)); // right alt
    vecs.push_back(mkv(1, 0, 0, 8'h05, 16'hFEFE, 5'h1F, 11'h000, 3'b100));
    vecs.push_back(mkv(1, 1, 0, 8'h11, 16'hFEFE, 5'h1F, 11'h000, 3'b000));
    vecs.push_back(mkv(1, 0, 1, 8'h1C, 16'hFDFE, 5'h1E, 11'h000, 3'b000)); // A
    vecs.push_back(mkv(1, 0, 1, 8'h15, 16'hFBFE, 5'h1E, 11'h000, 3'b000)); // Q
    vecs.push_back(mkv(0, 0, 0, 8'h00, 16'h00FE, 5'h1E, 11'h000, 3'b000));
    vecs.push_back(mkv(0, 0, 0, 8'h00, 16'hFFFE, 5'h1F, 11'h000, 3'b000)); // no row
    vecs.push_back(mkv(1, 0, 0, 8'h1C, 16'h00FE, 5'h1E, 11'h000, 3'b000));
    vecs.push_back(mkv(1, 0, 0, 8'h15, 16'h00FE, 5'h1F, 11'h000, 3'b000));

    reset   = 1'b1;
    ps2_key = 11'h000;
    addr    = 16'hFEFE;
    model_clear();
    idle(3);
    reset = 1'b0;
    idle(1);
    check("reset key_data", 16'(key_data), 16'h1F);
    check("reset Fn", 16'(fn), 16'h0);
    check("reset mod", 16'(mod), 16'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      addr = vecs[i].a;
      if (vecs[i].ev) send(vecs[i].ext, vecs[i].prs, vecs[i].code);
      else            idle(1);
      $display("vec%0d ev=%0d e0=%0d p=%0d code=%h addr=%h -> key_data=%h Fn=%h mod=%b",
               i, vecs[i].ev, vecs[i].ext, vecs[i].prs, vecs[i].code, addr, key_data, fn, mod);
      check($sformatf("vec%0d key_data", i), 16'(key_data), 16'(vecs[i].kd));
      check($sformatf("vec%0d Fn", i), 16'(fn), 16'(vecs[i].f));
      check($sformatf("vec%0d mod", i), 16'(mod), 16'(vecs[i].md));
    end

    // ctrl+F11 held with the toggle stable: nothing may change.
    addr = 16'hFEFE;
    send(1'b0, 1'b1, 8'h14);
    send(1'b0, 1'b1, 8'h78);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      check($sformatf("hold%0d Fn", i), 16'(fn), 16'h400);
      check($sformatf("hold%0d mod", i), 16'(mod), 16'h2);
    end
    send(1'b0, 1'b0, 8'h78);
    check("f11 release Fn", 16'(fn), 16'h0);
    send(1'b0, 1'b0, 8'h14);
    check("ctrl release mod", 16'(mod), 16'h0);

    // Reset while keys are held, with an event arriving on the same edge.
    send(1'b0, 1'b1, 8'h1C);
    send(1'b0, 1'b1, 8'h15);
    addr = 16'h00FE;
    idle(1);
    check("hold AQ key_data", 16'(key_data), 16'h1E);
    reset   = 1'b1;
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1A};
    idle(1);
    reset = 1'b0;
    model_clear();
    idle(1);
    check("mid reset key_data", 16'(key_data), 16'h1F);
    check("mid reset Fn", 16'(fn), 16'h0);
    check("mid reset mod", 16'(mod), 16'h0);
    idle(3);
    check("post reset key_data", 16'(key_data), 16'h1F);
    $display("reset-with-event -> key_data=%h Fn=%h mod=%b", key_data, fn, mod);

    // Random events against the key-set model.
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++)
        if (row_codes[r][c] != 0) pool.push_back(row_codes[r][c]);
    pool.push_back('h12); pool.push_back('h59); pool.push_back('h14); pool.push_back('h11);
    pool.push_back('h66); pool.push_back('h6B); pool.push_back('h72); pool.push_back('h75);
    pool.push_back('h74);
    for (int n = 0; n < 11; n++) pool.push_back(fn_codes[n]);

    for (int t = 0; t < 300; t++) begin
      logic [7:0] code;
      bit         ext;
      bit         prs;
      if ($urandom_range(0, 9) == 0) code = 8'($urandom);
      else code = 8'(pool[$urandom_range(0, pool.size() - 1)]);
      if (code == 8'h6B || code == 8'h72 || code == 8'h75 || code == 8'h74)
        ext = ($urandom_range(0, 3) != 0);
      else
        ext = ($urandom_range(0, 3) == 0);
      prs = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 0) addr = {~(8'h01 << $urandom_range(0, 7)), 8'($urandom)};
      else                           addr = 16'($urandom);
      if ($urandom_range(0, 7) == 0) idle(1);
      else                           send(ext, prs, code);
      $display("rnd%0d e0=%0d p=%0d code=%h addr=%h -> key_data=%h Fn=%h mod=%b",
               t, ext, prs, code, addr, key_data, fn, mod);
      check($sformatf("rnd%0d key_data", t), 16'(key_data), 16'(exp_kd(addr)));
      check($sformatf("rnd%0d Fn", t), 16'(fn), 16'(exp_fn()));
      check($sformatf("rnd%0d mod", t), 16'(mod), 16'(exp_mod()));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/zx8x_key_matrix.md
Name: zx8x_key_matrix

Overview:
- Upstream HID stage feeding the ULA keyboard port read path.
- Decodes MiSTer `ps2_key` events (PS/2 set-2 scancodes) into a held-key state matrix of 8 rows × 5 columns, matching the ZX80/ZX81 keyboard layout.
- Returns active-low column data for the row(s) selected by the CPU high address byte.
- Also exports function-key and modifier state, used for the ctrl+F11 reset and similar.

Parameters:
- CURSOR_MAP, 1: 1 = arrow keys and Backspace generate SHIFT+digit compound keys; 0 = ignore them.
- NUM_FN, 11: number of function keys tracked (F1..F11); fixed width of `Fn` port.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high; clock clk_sys
- ps2_key  in  11  [10] toggle strobe, [9] 1=press/0=release, [8] E0-extended, [7:0] scancode
- addr  in  16  CPU address; addr[15:8] active-low row select
- key_data  out  5  active-low column data, bit0 = outermost key of row
- Fn  out  11  Fn[n]=1 while Fn held (index 1..11)
- mod  out  3  {alt, ctrl, shift} held, either side

Behaviour:
- Reset: all matrix bits, virtual-shift bits, `Fn` and `mod` cleared (nothing held). `key_data` = 5'h1F. The `old_toggle` register loads `ps2_key[10]` so that no event fires on reset exit.
- Event detect: event when `ps2_key[10] != old_toggle`, registered each cycle.
  - State update happens on the same edge that registers `old_toggle`.
  - Matrix/`Fn`/`mod` reflect the event 1 clk after the toggle change is presented.
- Press sets the mapped bit; release clears it.
  - Release of a key not held: no change.
  - Repeated press (typematic): idempotent.
  - Unmapped scancodes: ignored entirely.
- Matrix rows (cols 0..4), non-extended codes:
  - A8: LSHIFT 12 / RSHIFT 59, Z 1A, X 22, C 21, V 2A
  - A9: A 1C, S 1B, D 23, F 2B, G 34
  - A10: Q 15, W 1D, E 24, R 2D, T 2C
  - A11: 1 16, 2 1E, 3 26, 4 25, 5 2E
  - A12: 0 45, 9 46, 8 3E, 7 3D, 6 36
  - A13: P 4D, O 44, I 43, U 3C, Y 35
  - A14: ENTER 5A, L 4B, K 42, J 3B, H 33
  - A15: SPACE 29, . 49, M 3A, N 31, B 32
- Left and right shift are held as separate bits; SHIFT position = OR of both plus virtual shift.
- Compound keys (CURSOR_MAP=1): separate bits per virtual key.
  - E0 6B → SHIFT+5
  - E0 72 → SHIFT+6
  - E0 75 → SHIFT+7
  - E0 74 → SHIFT+8
  - 66 (Backspace) → SHIFT+0
- Matrix position active = physical bit OR virtual bit, so releasing a cursor key never clears a physically held digit or shift, and vice versa.
- Fn codes: 05 06 04 0C 03 0B 83 0A 01 09 78 → Fn[1..11], non-extended only.
- Modifiers:
  - ctrl = 14 (plain or E0).
  - alt = 11 (plain or E0).
  - shift = either shift key.
  - Extended 12/59 (fake shifts) ignored.
- Extended flag must match the table; e.g. E0 5A (keypad Enter) maps to ENTER, any other unlisted E0 code is ignored.
- key_data: combinational from registered state. For each column c: key_data[c] = ~OR over rows r with addr[8+r]==0 of held[r][c].
  - Multiple low address bits → wired-AND behaviour.
  - addr[15:8]=FF → 1F.
- Simultaneous event and reset: reset wins, event discarded.

Decomposition:
- Package `zx8x_kbd_pkg`:
  - scancode constants
  - row/col index typedefs (row_t 3-bit, col_t 3-bit)
  - key-map entry struct {valid, row, col, virt_shift}
- Sub-module `zx8x_scancode_map`: pure combinational lookup {ext, code} → map entry + fn index + mod index.
- Top: edge detect, state registers, row mux.

Test Plan:
- Reset, then addr=FEFE with no events → key_data=1F; `Fn`=0, `mod`=0.
- Press 1A (Z), addr=FEFE → 1D one clk after toggle; release 1A → 1F; addr=FDFE → 1F throughout.
- Press E0 6B (left): addr=FEFE → 1E, addr=F7FE → 0F. Press real 12, release E0 6B → addr=FEFE still 1E, F7FE → 1F.
- Press 12 and 59, release 12 → shift still held (`mod`=3'b001, FEFE → 1E); release 59 → 1F.
- Press 14 then 78 → mod[1]=1, Fn[11]=1. Toggle unchanged for 10 cycles → no further change. Release 78 → Fn=0.
- Press A (1C) and Q (15), addr=00FE → 1E; assert reset mid-hold → all released, 1F, no spurious event after reset.
